seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_multiplier_shift_add_step.sv | 20 ++
 rtl/seq_multiplier.sv | 126 ++++++++++++
 tb/tb_seq_multiplier.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state
// encodings, default operand width and the iteration-counter width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 18;

  // Counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// One combinational shift-add iteration: conditionally add the multiplicand
// into the accumulator upper half, then shift the whole accumulator right.
module shift_add_step #(
  parameter int WIDTH = 18
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               lsb,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;

  // The carry lands in sum[WIDTH] and becomes the new accumulator MSB.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (lsb ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one shift-add step per cycle.
// Optional signed mode (SGN) is built only when SEQ_MULT_SIGNED_EN is defined.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] SRC1,
  input  logic [WIDTH-1:0] SRC2,
  input  logic             SGN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT_LO,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             OVF
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0]   mcand, mplr, op1, op2;
  logic               last, ovf_nx;

  assign last = (cnt == CW'(WIDTH));

`ifdef SEQ_MULT_SIGNED_EN
  logic neg, neg_in;

  // Iterate on magnitudes; the sign is reapplied when the result is captured.
  assign op1    = (SGN && SRC1[WIDTH-1]) ? -SRC1 : SRC1;
  assign op2    = (SGN && SRC2[WIDTH-1]) ? -SRC2 : SRC2;
  assign neg_in = SGN & (SRC1[WIDTH-1] ^ SRC2[WIDTH-1]);
  assign prod   = neg ? -acc : acc;

  logic sgn_q;
  always_comb begin
    if (sgn_q)
      ovf_nx = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    else
      ovf_nx = |prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      neg   <= 1'b0;
      sgn_q <= 1'b0;
    end else if (state == ST_IDLE && START) begin
      neg   <= neg_in;
      sgn_q <= SGN;
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = SGN;
  assign op1        = SRC1;
  assign op2        = SRC2;
  assign prod       = acc;
  assign ovf_nx     = |prod[2*WIDTH-1:WIDTH];
`endif

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .lsb      (mplr[0]),
    .acc_next (acc_nx)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (START) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // RUN spends WIDTH cycles stepping and one more capturing the product,
  // which puts DONE WIDTH+1 edges after the accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      RESULT_LO <= '0;
      RESULT_HI <= '0;
      OVF       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (START) begin
          mcand <= op1;
          mplr  <= op2;
          acc   <= '0;
          cnt   <= '0;
        end
        ST_RUN: begin
          if (last) begin
            RESULT_LO <= prod[WIDTH-1:0];
            RESULT_HI <= prod[2*WIDTH-1:WIDTH];
            OVF       <= ovf_nx;
          end else begin
            acc  <= acc_nx;
            mplr <= mplr >> 1;
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: a cycle-level reference model queues expected results
// on acceptance; a negedge monitor checks DONE/BUSY/results every cycle.
module tb_seq_multiplier;

  localparam int W = 18;

  logic         CLK = 1'b0, RST = 1'b1, START = 1'b0, SGN = 1'b0;
  logic [W-1:0] SRC1 = '0, SRC2 = '0;
  logic         BUSY, DONE, OVF;
  logic [W-1:0] RESULT_LO, RESULT_HI;

  seq_multiplier #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SRC1(SRC1), .SRC2(SRC2), .SGN(SGN),
    .BUSY(BUSY), .DONE(DONE), .RESULT_LO(RESULT_LO), .RESULT_HI(RESULT_HI), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0, busy_end = -10;
  logic         rst_edge = 1'b0;
  logic [W-1:0] h_lo = '0, h_hi = '0;
  logic         h_ovf = 1'b0;
  int           tests = 0, fails = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int due);
    exp_t   e;
    longint p, lim;
    logic [63:0] pv;
    logic   ovf;
    lim = longint'(1) << (W - 1);
    p   = longint'(a) * longint'(b);
    ovf = (p >= (longint'(1) << W));
`ifdef SEQ_MULT_SIGNED_EN
    if (s) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      ovf = (p < -lim) || (p > lim - 1);
    end
`else
    if (s && lim < 0) ovf = 1'b0;
`endif
    pv    = 64'(p);
    e.lo  = pv[W-1:0];
    e.hi  = pv[2*W-1:W];
    e.ovf = ovf;
    e.due = due;
    return e;
  endfunction

  // Reference model: accept when idle; done WIDTH+1 edges later; idle again after.
  always @(posedge CLK) begin
    cyc++;
    rst_edge = RST;
    if (RST) begin
      q.delete();
      busy_end = -10;
    end else if (START && cyc > busy_end + 1) begin
      q.push_back(model(SRC1, SRC2, SGN, cyc + W + 1));
      busy_end = cyc + W + 1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic exp_done;
    if (cyc > 0) begin
      if (rst_edge) begin
        h_lo = '0; h_hi = '0; h_ovf = 1'b0;
      end
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      chk("done", W'(DONE), W'(exp_done));
      if (exp_done) begin
        e = q.pop_front();
        h_lo = e.lo; h_hi = e.hi; h_ovf = e.ovf;
      end
      chk("busy", W'(BUSY), W'(cyc <= busy_end));
      chk("result_lo", RESULT_LO, h_lo);
      chk("result_hi", RESULT_HI, h_hi);
      chk("ovf", W'(OVF), W'(h_ovf));
    end
  end

  // Called at a negedge with the DUT idle; returns when the next start is accepted.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    START = 1'b1; SRC1 = a; SRC2 = b; SGN = s;
    @(negedge CLK);
    START = 1'b0;
    repeat (W + 2) begin
      SRC1 = W'($urandom()); SRC2 = W'($urandom()); SGN = 1'($urandom());
      @(negedge CLK);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    op(W'(3), W'(5), 1'b0);
    op('1, '1, 1'b0);
    op(W'(512), W'(512), 1'b0);
    op(W'(511), W'(512), 1'b0);
    op('0, W'(12345), 1'b0);
    op(W'(777), '0, 1'b0);
    op(W'(18'h3FFFD), W'(5), 1'b1);
    op(W'(5), W'(18'h3FFFD), 1'b1);
    op(W'(1) << (W - 1), W'(1) << (W - 1), 1'b1);

    // START held with operands churning every cycle
    START = 1'b1;
    repeat (30) begin
      SRC1 = W'($urandom()); SRC2 = W'($urandom()); SGN = 1'($urandom());
      @(negedge CLK);
    end
    START = 1'b0;
    repeat (W + 3) @(negedge CLK);

    // Reset seven cycles into a run, with START also high
    START = 1'b1; SRC1 = W'(3); SRC2 = W'(5); SGN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    RST = 1'b1; START = 1'b1;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    repeat (2) @(negedge CLK);
    op(W'(3), W'(5), 1'b0);

    repeat (40) begin
      op(pick(), pick(), 1'($urandom()));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (W + 6) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
